mole_hole_scheduler: RTL and testbench

- Sequences the single mole-up/mole-down timing stream onto N physical holes.
- On every new mole period it picks a pseudo-random hole, lights that hole's LED, and judges the player's button presses.
- Outputs a saturating score plus one-cycle hit/miss/wrong pulses.
- Sits between the game FSM outputs (game_in_progress, mole_clk) and the board LEDs, buttons and score display.

---
 rtl/whack_a_mole_pkg.sv | 31 +++
 rtl/mole_lfsr.sv | 24 ++
 rtl/mole_hole_scheduler.sv | 132 +++++++++++++
 tb/tb_mole_hole_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/whack_a_mole_pkg.sv
// Shared types, LFSR constants and hole selection for the mole scheduler.
// Imported by mole_lfsr and mole_hole_scheduler.
package whack_a_mole_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_UP,
    UP,
    WHACKED
  } sched_state_t;

  localparam int          LFSR_W        = 16;
  // taps at bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  // Candidate hole from the low LFSR nibble; a repeat of the previous
  // hole is bumped to the next hole so consecutive moles never match.
  function automatic logic [3:0] pick_hole(
    input logic [LFSR_W-1:0] rnd,
    input logic [3:0]        prev,
    input int                n
  );
    int c;
    c = int'(rnd[3:0]) % n;
    if (c == int'(prev))
      c = (int'(prev) + 1) % n;
    return 4'(c);
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Fibonacci LFSR, shifts left, free-running every clock.
// Ports: clk, reset_button_pressed (sync, high), state (current value).
module mole_lfsr
  import whack_a_mole_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              reset_button_pressed,
  output logic [LFSR_W-1:0] state
);

  logic fb;

  assign fb = ^(state & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (reset_button_pressed)
      state <= SEED;
    else
      state <= {state[LFSR_W-2:0], fb};
  end

endmodule

// File: rtl/mole_hole_scheduler.sv
// Maps the mole up/down stream onto N holes, judges presses, keeps score.
// Ports: clk, reset_button_pressed, game_in_progress, mole_clk,
//   hole_buttons -> mole_leds, score, hit_pulse, miss_pulse, wrong_pulse.
module mole_hole_scheduler
  import whack_a_mole_pkg::*;
#(
  parameter int          N_HOLES   = 8,
  parameter int          MAX_SCORE = 99,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         SW        = $clog2(MAX_SCORE + 1)
) (
  input  logic               clk,
  input  logic               reset_button_pressed,
  input  logic               game_in_progress,
  input  logic               mole_clk,
  input  logic [N_HOLES-1:0] hole_buttons,
  output logic [N_HOLES-1:0] mole_leds,
  output logic [SW-1:0]      score,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               wrong_pulse
);

  localparam logic [N_HOLES-1:0] ONE = {{(N_HOLES-1){1'b0}}, 1'b1};

  sched_state_t       state;
  logic               mole_q;
  logic               game_q;
  logic [N_HOLES-1:0] btn_q;
  logic               mole_rise;
  logic               mole_fall;
  logic               game_rise;
  logic [N_HOLES-1:0] btn_rise;
  logic [LFSR_W-1:0]  lfsr;
  logic [3:0]         hole;
  logic [3:0]         prev_hole;
  logic [3:0]         cand;
  logic [N_HOLES-1:0] cand_mask;
  logic [N_HOLES-1:0] hole_mask;
  logic               hit;
  logic               wrong;

  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk                  (clk),
    .reset_button_pressed (reset_button_pressed),
    .state                (lfsr)
  );

  assign mole_rise = mole_clk & ~mole_q;
  assign mole_fall = ~mole_clk & mole_q;
  assign game_rise = game_in_progress & ~game_q;
  assign btn_rise  = hole_buttons & ~btn_q;

  assign cand      = pick_hole(lfsr, prev_hole, N_HOLES);
  assign cand_mask = ONE << cand;
  assign hole_mask = ONE << hole;
  assign hit       = |(btn_rise & hole_mask);
  assign wrong     = |(btn_rise & ~hole_mask);

  always_ff @(posedge clk) begin
    if (reset_button_pressed) begin
      state       <= IDLE;
      mole_q      <= 1'b0;
      game_q      <= 1'b0;
      btn_q       <= '0;
      hole        <= '0;
      prev_hole   <= '0;
      mole_leds   <= '0;
      score       <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      wrong_pulse <= 1'b0;
    end else begin
      mole_q      <= mole_clk;
      game_q      <= game_in_progress;
      btn_q       <= hole_buttons;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      wrong_pulse <= 1'b0;
      // losing the game overrides everything; score stays for display
      if (state != IDLE && !game_in_progress) begin
        state     <= IDLE;
        mole_leds <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            mole_leds <= '0;
            if (game_rise) begin
              score <= '0;
              state <= WAIT_UP;
            end
          end
          WAIT_UP: begin
            if (mole_rise) begin
              hole      <= cand;
              prev_hole <= cand;
              mole_leds <= cand_mask;
              state     <= UP;
            end
          end
          UP: begin
            wrong_pulse <= wrong;
            if (hit) begin
              hit_pulse <= 1'b1;
              mole_leds <= '0;
              if (score != SW'(MAX_SCORE))
                score <= score + 1'b1;
              // a hit on the falling edge already ends the mole
              state <= mole_fall ? WAIT_UP : WHACKED;
            end else if (mole_fall) begin
              miss_pulse <= 1'b1;
              mole_leds  <= '0;
              state      <= WAIT_UP;
            end
          end
          WHACKED: begin
            mole_leds <= '0;
            if (mole_fall)
              state <= WAIT_UP;
          end
          default: begin
            state     <= IDLE;
            mole_leds <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_hole_scheduler.sv
// Randomized and directed bench for mole_hole_scheduler against
// a behavioural game model.
module tb_mole_hole_scheduler;

  localparam int N    = 8;
  localparam int MAXS = 99;
  localparam int SW   = $clog2(MAXS + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic         game;
  logic         mole;
  logic [N-1:0] btn;
  logic [N-1:0] mole_leds;
  logic [SW-1:0] score;
  logic         hit_pulse;
  logic         miss_pulse;
  logic         wrong_pulse;

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  mole_hole_scheduler #(
    .N_HOLES   (N),
    .MAX_SCORE (MAXS),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk                  (clk),
    .reset_button_pressed (rst),
    .game_in_progress     (game),
    .mole_clk             (mole),
    .hole_buttons         (btn),
    .mole_leds            (mole_leds),
    .score                (score),
    .hit_pulse            (hit_pulse),
    .miss_pulse           (miss_pulse),
    .wrong_pulse          (wrong_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // behavioural model: a game is on, a mole may be up awaiting judgment,
  // or the current mole has already been whacked
  logic [15:0]  m_lfsr;
  int           m_prev;
  int           m_act;
  int           e_score;
  logic [N-1:0] e_leds;
  bit           e_hit, e_miss, e_wrong;
  bit           playing, up, whk;
  bit           p_mole, p_game;
  logic [N-1:0] p_btn;
  logic [N-1:0] brise;
  bit           mrise, mfall, grise;
  int           pick;

  always @(posedge clk) begin
    if (rst) begin
      m_lfsr  = 16'hACE1;
      m_prev  = 0;
      m_act   = 0;
      e_score = 0;
      e_leds  = '0;
      e_hit   = 0;
      e_miss  = 0;
      e_wrong = 0;
      playing = 0;
      up      = 0;
      whk     = 0;
      p_mole  = 0;
      p_game  = 0;
      p_btn   = '0;
    end else begin
      mrise   = mole && !p_mole;
      mfall   = !mole && p_mole;
      grise   = game && !p_game;
      brise   = btn & ~p_btn;
      e_hit   = 0;
      e_miss  = 0;
      e_wrong = 0;
      if (!playing) begin
        e_leds = '0;
        if (grise) begin
          playing = 1;
          e_score = 0;
        end
      end else if (!game) begin
        playing = 0;
        up      = 0;
        whk     = 0;
        e_leds  = '0;
      end else if (up) begin
        for (int h = 0; h < N; h++)
          if (brise[h] && h != m_act) e_wrong = 1;
        if (brise[m_act]) begin
          e_hit   = 1;
          e_score = (e_score + 1 > MAXS) ? MAXS : e_score + 1;
          e_leds  = '0;
          up      = 0;
          whk     = !mfall;
        end else if (mfall) begin
          e_miss = 1;
          e_leds = '0;
          up     = 0;
        end
      end else if (whk) begin
        if (mfall) whk = 0;
      end else if (mrise) begin
        pick = int'(m_lfsr[3:0]) % N;
        if (pick == m_prev) pick = (m_prev + 1) % N;
        m_act  = pick;
        m_prev = pick;
        up     = 1;
        e_leds = '0;
        e_leds[pick] = 1'b1;
      end
      p_mole = mole;
      p_game = game;
      p_btn  = btn;
      m_lfsr = {m_lfsr[14:0],
                m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("leds", mole_leds, e_leds);
      chk("score", score, e_score);
      chk("hit", hit_pulse, e_hit);
      chk("miss", miss_pulse, e_miss);
      chk("wrong", wrong_pulse, e_wrong);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [N-1:0] bit_of(input int h);
    logic [N-1:0] v;
    v    = '0;
    v[h] = 1'b1;
    return v;
  endfunction

  logic [N-1:0] last_leds;

  initial begin
    rst  = 1'b1;
    game = 1'b0;
    mole = 1'b0;
    btn  = '0;
    step(1);
    armed = 1'b1;
    step(2);
    chk("rst_leds", mole_leds, 0);
    chk("rst_score", score, 0);
    rst = 1'b0;
    step(1);
    game = 1'b1;
    step(6);

    // first mole: LED one cycle after the rise
    mole = 1'b1;
    step(1);
    chk("first_led", mole_leds, bit_of(m_act));
    chk("first_score", score, 0);

    // correct whack, then a repeat press on the whacked mole
    btn = bit_of(m_act);
    step(1);
    chk("hit_p", hit_pulse, 1);
    chk("hit_score", score, 1);
    chk("hit_led_off", mole_leds, 0);
    btn = '0;
    step(1);
    chk("hit_one_cyc", hit_pulse, 0);
    btn = bit_of(m_act);
    step(1);
    chk("rehit_none", hit_pulse, 0);
    chk("rehit_wrong", wrong_pulse, 0);
    btn  = '0;
    mole = 1'b0;
    step(2);

    // wrong press keeps the mole lit, then it retracts as a miss
    mole = 1'b1;
    step(1);
    btn = bit_of((m_act + 1) % N);
    step(1);
    chk("wrong_p", wrong_pulse, 1);
    chk("wrong_led", mole_leds, bit_of(m_act));
    chk("wrong_score", score, 1);
    btn = '0;
    step(1);
    mole = 1'b0;
    step(1);
    chk("miss_p", miss_pulse, 1);
    step(1);
    chk("miss_one_cyc", miss_pulse, 0);

    // hit on the same edge as the fall
    mole = 1'b1;
    step(2);
    btn  = bit_of(m_act);
    mole = 1'b0;
    step(1);
    chk("hitfall_hit", hit_pulse, 1);
    chk("hitfall_miss", miss_pulse, 0);
    chk("hitfall_score", score, 2);
    btn = '0;
    step(1);

    // long run of hits: saturation and no repeated hole
    last_leds = '0;
    for (int i = 0; i < 120; i++) begin
      mole = 1'b1;
      step(1);
      chk("norepeat", (mole_leds == last_leds), 0);
      last_leds = mole_leds;
      btn = bit_of(m_act);
      step(1);
      chk("sat_hit", hit_pulse, 1);
      btn  = '0;
      mole = 1'b0;
      step(2);
    end
    chk("sat_score", score, MAXS);

    // game ends while a mole is up
    mole = 1'b1;
    step(2);
    game = 1'b0;
    step(1);
    chk("drop_leds", mole_leds, 0);
    chk("drop_score", score, MAXS);
    mole = 1'b0;
    step(2);
    game = 1'b1;
    step(1);
    chk("restart_score", score, 0);

    // random play
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) mole = ~mole;
      if ($urandom_range(0, 80) == 0) game = ~game;
      case ($urandom_range(0, 5))
        0:       btn = bit_of(m_act);
        1:       btn = N'($urandom);
        default: btn = '0;
      endcase
      step(1);
    end

    // reset while a mole is up
    btn  = '0;
    game = 1'b0;
    mole = 1'b0;
    step(2);
    game = 1'b1;
    step(2);
    mole = 1'b1;
    step(2);
    chk("pre_rst_led", mole_leds, bit_of(m_act));
    rst = 1'b1;
    step(1);
    chk("rst_up_leds", mole_leds, 0);
    chk("rst_up_score", score, 0);
    chk("rst_up_hit", hit_pulse, 0);
    chk("rst_up_lfsr", dut.u_lfsr.state, 16'hACE1);
    rst = 1'b0;
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
